dark_linebuf: RTL and testbench

Receive-side line editor sitting directly downstream of the UART receiver and in front of the core bus. It consumes received bytes, assembles them into a line buffer with backspace editing, and echoes typed characters back toward the UART transmitter. It presents the finished line to the core as a memory-mapped byte queue with a level IRQ. The core therefore handles whole lines instead of servicing every character.

---
 rtl/dark_linebuf_pkg.sv | 25 ++
 rtl/dark_linebuf_ram.sv | 22 ++
 rtl/dark_linebuf.sv | 181 ++++++++++++++++++
 tb/tb_dark_linebuf.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dark_linebuf_pkg.sv
// Shared constants for the receive-side line editor: FSM encodings,
// control characters and STATUS bit positions.
package dark_linebuf_pkg;

  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_ECHO    = 2'd1;
  localparam logic [1:0] ST_EOL     = 2'd2;
  localparam logic [1:0] ST_READY   = 2'd3;

  localparam logic [7:0] CH_CR  = 8'h0D;
  localparam logic [7:0] CH_LF  = 8'h0A;
  localparam logic [7:0] CH_BS  = 8'h08;
  localparam logic [7:0] CH_DEL = 8'h7F;
  localparam logic [7:0] CH_SP  = 8'h20;

  localparam int STAT_READY   = 0;
  localparam int STAT_OVF     = 1;
  localparam int STAT_ECHOREQ = 2;

  // Both BS and DEL erase the previous character.
  function automatic logic is_erase(input logic [7:0] b);
    return (b == CH_BS) || (b == CH_DEL);
  endfunction

endpackage

// File: rtl/dark_linebuf_ram.sv
// Line storage: one synchronous write port, one asynchronous read port.
module dark_linebuf_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/dark_linebuf.sv
// Line editor between the UART receiver and the core bus: collects a line with
// backspace editing, echoes edits to the transmitter, and exposes the line as a byte queue.
module dark_linebuf
  import dark_linebuf_pkg::*;
#(
  parameter int DEPTH = 64,
  parameter bit ECHO  = 1'b1
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RXSTB,
  input  logic [7:0]  RXDATA,
  output logic        ECHOREQ,
  output logic [7:0]  ECHODATA,
  input  logic        ECHOACK,
  input  logic        RD,
  input  logic        WR,
  input  logic [3:0]  BE,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        IRQ,
  output logic [3:0]  DEBUG
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] CNT_MAX = AW'(DEPTH - 1);

  logic [1:0]    state;
  logic [AW-1:0] cnt;
  logic [AW-1:0] rptr;
  logic          ovf;
  logic [1:0]    seq_idx;
  logic          seq_erase;
  logic [7:0]    echo_char;
  logic [7:0]    echo_byte;
  logic [7:0]    rd_byte;
  logic [7:0]    status;

  logic discard, ovf_clr, pop, rx, in_collect;
  logic is_cr, is_lf, is_term, is_char, full;
  logic buf_we, ovf_set, ack, seq_last, release_line;
  logic [AW-1:0] rptr_inc;
  logic unused_bits;

  assign unused_bits = ^{DATAI[31:2], BE[3:2]};

  assign discard    = WR & BE[0] & DATAI[0];
  assign ovf_clr    = WR & BE[0] & DATAI[1];
  assign pop        = RD & BE[1] & (state == ST_READY);
  assign rx         = RXSTB & ~discard;
  assign in_collect = (state == ST_COLLECT);

  assign is_cr   = (RXDATA == CH_CR);
  assign is_lf   = (RXDATA == CH_LF);
  assign is_term = is_cr | (is_lf & (cnt != '0));
  assign is_char = ~is_cr & ~is_lf & ~is_erase(RXDATA);
  assign full    = (cnt == CNT_MAX);

  assign buf_we  = rx & in_collect & is_char & ~full;
  // Any byte that arrives while the editor is busy is lost, as is a printable byte on a full line.
  assign ovf_set = rx & (~in_collect | (is_char & full));

  assign ECHOREQ = ECHO & ((state == ST_ECHO) | (state == ST_EOL));
  assign ack     = ECHOREQ & ECHOACK;

  always_comb begin
    seq_last = 1'b0;
    if (state == ST_EOL)  seq_last = (seq_idx == 2'd1);
    else if (seq_erase)   seq_last = (seq_idx == 2'd2);
    else                  seq_last = (seq_idx == 2'd0);
  end

  // Erase sequence is BS, SP, BS; end-of-line sequence is CR, LF.
  always_comb begin
    echo_byte = 8'h00;
    if (state == ST_EOL)
      echo_byte = (seq_idx == 2'd0) ? CH_CR : CH_LF;
    else if (state == ST_ECHO) begin
      if (seq_erase) echo_byte = (seq_idx == 2'd1) ? CH_SP : CH_BS;
      else           echo_byte = echo_char;
    end
  end

  assign ECHODATA = ECHOREQ ? echo_byte : 8'h00;

  assign rptr_inc     = rptr + AW'(1);
  assign release_line = (cnt == '0) | (rptr_inc == cnt);

  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state     <= ST_COLLECT;
      cnt       <= '0;
      rptr      <= '0;
      seq_idx   <= 2'd0;
      seq_erase <= 1'b0;
      echo_char <= 8'h00;
    end else if (discard) begin
      state   <= ST_COLLECT;
      cnt     <= '0;
      rptr    <= '0;
      seq_idx <= 2'd0;
    end else begin
      case (state)
        ST_COLLECT: begin
          if (RXSTB) begin
            if (is_term) begin
              state   <= ECHO ? ST_EOL : ST_READY;
              seq_idx <= 2'd0;
            end else if (is_erase(RXDATA)) begin
              if (cnt != '0) begin
                cnt <= cnt - AW'(1);
                if (ECHO) begin
                  state     <= ST_ECHO;
                  seq_erase <= 1'b1;
                  seq_idx   <= 2'd0;
                end
              end
            end else if (is_char && !full) begin
              cnt <= cnt + AW'(1);
              if (ECHO) begin
                state     <= ST_ECHO;
                seq_erase <= 1'b0;
                seq_idx   <= 2'd0;
                echo_char <= RXDATA;
              end
            end
          end
        end
        ST_ECHO, ST_EOL: begin
          if (ack) begin
            if (seq_last) begin
              state   <= (state == ST_EOL) ? ST_READY : ST_COLLECT;
              seq_idx <= 2'd0;
            end else begin
              seq_idx <= seq_idx + 2'd1;
            end
          end
        end
        default: begin
          if (pop) begin
            if (release_line) begin
              cnt   <= '0;
              rptr  <= '0;
              state <= ST_COLLECT;
            end else begin
              rptr <= rptr_inc;
            end
          end
        end
      endcase
    end
  end

  // A same-cycle overflow outranks the software clear so no drop goes unreported.
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)          ovf <= 1'b0;
    else if (ovf_set) ovf <= 1'b1;
    else if (ovf_clr) ovf <= 1'b0;
  end

  dark_linebuf_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk   (CLK),
    .we    (buf_we),
    .waddr (cnt),
    .wdata (RXDATA),
    .raddr (rptr),
    .rdata (rd_byte)
  );

  always_comb begin
    status               = 8'h00;
    status[STAT_READY]   = (state == ST_READY);
    status[STAT_OVF]     = ovf;
    status[STAT_ECHOREQ] = ECHOREQ;
  end

  assign DATAO = {8'd0, 8'(cnt), rd_byte, status};
  assign IRQ   = (state == ST_READY);
  assign DEBUG = {state, ovf, ECHOREQ};

endmodule

// File: tb/tb_dark_linebuf.sv
// Directed bench for dark_linebuf (DEPTH=4, ECHO=1): echo bytes are checked by a
// scoreboard monitor, register views by direct comparisons against hand-computed values.
module tb_dark_linebuf;

  logic        CLK = 1'b0;
  logic        RES;
  logic        RXSTB;
  logic [7:0]  RXDATA;
  logic        ECHOREQ;
  logic [7:0]  ECHODATA;
  logic        ECHOACK;
  logic        RD;
  logic        WR;
  logic [3:0]  BE;
  logic [31:0] DATAI;
  logic [31:0] DATAO;
  logic        IRQ;
  logic [3:0]  DEBUG;

  int checks = 0;
  int errors = 0;
  logic [7:0] echo_q[$];

  wire [7:0] status  = DATAO[7:0];
  wire [7:0] rd_byte = DATAO[15:8];
  wire [7:0] len     = DATAO[23:16];

  always #5 CLK = ~CLK;

  dark_linebuf #(.DEPTH(4), .ECHO(1'b1)) dut (
    .CLK      (CLK),
    .RES      (RES),
    .RXSTB    (RXSTB),
    .RXDATA   (RXDATA),
    .ECHOREQ  (ECHOREQ),
    .ECHODATA (ECHODATA),
    .ECHOACK  (ECHOACK),
    .RD       (RD),
    .WR       (WR),
    .BE       (BE),
    .DATAI    (DATAI),
    .DATAO    (DATAO),
    .IRQ      (IRQ),
    .DEBUG    (DEBUG)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every accepted echo byte must match the oldest expected byte.
  always @(negedge CLK) begin
    if (!RES && ECHOREQ && ECHOACK) begin
      if (echo_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL echo_unexpected: got 0x%0h, expected no echo at %0t", ECHODATA, $time);
      end else begin
        checkOutput("echo_byte", 32'(ECHODATA), 32'(echo_q.pop_front()));
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b);
    RXSTB  = 1'b1;
    RXDATA = b;
    @(posedge CLK); #1;
    RXSTB  = 1'b0;
  endtask

  task automatic waitEchoIdle();
    int n = 0;
    while (ECHOREQ && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    if (ECHOREQ) begin
      checks++;
      errors++;
      $display("[TB] FAIL echo_timeout: ECHOREQ still 1 after %0d cycles", n);
    end
  endtask

  task automatic sendEchoed(input string s);
    for (int i = 0; i < s.len(); i++) begin
      echo_q.push_back(s[i]);
      applyStimulus(s[i]);
      waitEchoIdle();
    end
  endtask

  task automatic sendLine();
    echo_q.push_back(8'h0D);
    echo_q.push_back(8'h0A);
    applyStimulus(8'h0D);
    waitEchoIdle();
  endtask

  task automatic popByte(input logic [7:0] exp_byte);
    RD = 1'b1;
    BE = 4'b0010;
    checkOutput("pop_byte", 32'(rd_byte), 32'(exp_byte));
    @(posedge CLK); #1;
    RD = 1'b0;
    BE = 4'b0000;
  endtask

  task automatic popOnly();
    RD = 1'b1;
    BE = 4'b0010;
    @(posedge CLK); #1;
    RD = 1'b0;
    BE = 4'b0000;
  endtask

  task automatic busWrite(input logic [31:0] d);
    WR    = 1'b1;
    BE    = 4'b0001;
    DATAI = d;
    @(posedge CLK); #1;
    WR    = 1'b0;
    BE    = 4'b0000;
    DATAI = 32'd0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RES = 1'b1; RXSTB = 1'b0; RXDATA = 8'h00; ECHOACK = 1'b1;
    RD = 1'b0; WR = 1'b0; BE = 4'b0000; DATAI = 32'd0;
    #12;
    checkOutput("reset_irq", 32'(IRQ), 0);
    checkOutput("reset_echoreq", 32'(ECHOREQ), 0);
    checkOutput("reset_echodata", 32'(ECHODATA), 0);
    checkOutput("reset_status", 32'(status), 0);
    checkOutput("reset_len", 32'(len), 0);
    checkOutput("reset_debug", 32'(DEBUG), 0);
    @(posedge CLK); #1;
    RES = 1'b0;
    @(posedge CLK); #1;

    $display("[TB] basic line with echo");
    sendEchoed("ab");
    sendLine();
    checkOutput("t1_irq", 32'(IRQ), 1);
    checkOutput("t1_len", 32'(len), 2);
    checkOutput("t1_status", 32'(status), 'h1);
    checkOutput("t1_debug", 32'(DEBUG), 'hC);
    popByte(8'h61);
    checkOutput("t1_irq_mid", 32'(IRQ), 1);
    popByte(8'h62);
    checkOutput("t1_irq_done", 32'(IRQ), 0);
    checkOutput("t1_len_done", 32'(len), 0);
    checkOutput("t1_debug_done", 32'(DEBUG), 0);

    $display("[TB] backspace editing");
    sendEchoed("abc");
    echo_q.push_back(8'h08); echo_q.push_back(8'h20); echo_q.push_back(8'h08);
    applyStimulus(8'h08);
    waitEchoIdle();
    checkOutput("t2_len_bs", 32'(len), 2);
    sendEchoed("d");
    sendLine();
    checkOutput("t2_len", 32'(len), 3);
    popByte(8'h61);
    popByte(8'h62);
    popByte(8'h64);
    checkOutput("t2_irq_done", 32'(IRQ), 0);
    applyStimulus(8'h08);
    checkOutput("t2_bs_empty_echoreq", 32'(ECHOREQ), 0);
    checkOutput("t2_bs_empty_len", 32'(len), 0);

    $display("[TB] overflow on full line");
    sendEchoed("abc");
    applyStimulus(8'h64);
    applyStimulus(8'h65);
    sendLine();
    checkOutput("t3_len", 32'(len), 3);
    checkOutput("t3_status_ovf", 32'(status), 'h3);
    busWrite(32'd2);
    checkOutput("t3_status_clr", 32'(status), 'h1);
    applyStimulus(8'h78);
    checkOutput("t3_status_ready_drop", 32'(status), 'h3);
    checkOutput("t3_len_ready_drop", 32'(len), 3);
    busWrite(32'd1);
    checkOutput("t3_discard_irq", 32'(IRQ), 0);
    checkOutput("t3_discard_len", 32'(len), 0);
    checkOutput("t3_discard_status", 32'(status), 'h2);
    busWrite(32'd2);
    checkOutput("t3_final_status", 32'(status), 0);

    $display("[TB] transmitter stall");
    ECHOACK = 1'b0;
    echo_q.push_back(8'h71);
    applyStimulus(8'h71);
    for (int i = 0; i < 20; i++) begin
      checkOutput("t4_stall_req", 32'(ECHOREQ), 1);
      checkOutput("t4_stall_data", 32'(ECHODATA), 'h71);
      @(posedge CLK); #1;
    end
    applyStimulus(8'h7A);
    checkOutput("t4_stall_status", 32'(status), 'h6);
    checkOutput("t4_stall_data_after", 32'(ECHODATA), 'h71);
    ECHOACK = 1'b1;
    waitEchoIdle();
    checkOutput("t4_len", 32'(len), 1);
    checkOutput("t4_status", 32'(status), 'h2);
    busWrite(32'd3);
    checkOutput("t4_cleanup_status", 32'(status), 0);

    $display("[TB] CRLF gives one empty line");
    sendLine();
    applyStimulus(8'h0A);
    checkOutput("t5_irq", 32'(IRQ), 1);
    checkOutput("t5_len", 32'(len), 0);
    checkOutput("t5_status", 32'(status), 'h3);
    popOnly();
    checkOutput("t5_irq_released", 32'(IRQ), 0);
    checkOutput("t5_debug", 32'(DEBUG), 'h2);
    busWrite(32'd2);

    $display("[TB] async reset mid-echo and discard priority");
    ECHOACK = 1'b0;
    applyStimulus(8'h6D);
    checkOutput("t6_pre_echoreq", 32'(ECHOREQ), 1);
    checkOutput("t6_pre_len", 32'(len), 1);
    #3 RES = 1'b1;
    #1;
    checkOutput("t6_rst_echoreq", 32'(ECHOREQ), 0);
    checkOutput("t6_rst_irq", 32'(IRQ), 0);
    checkOutput("t6_rst_len", 32'(len), 0);
    checkOutput("t6_rst_echodata", 32'(ECHODATA), 0);
    @(posedge CLK); #1;
    RES = 1'b0;
    ECHOACK = 1'b1;
    @(posedge CLK); #1;
    sendEchoed("abc");
    RXSTB = 1'b1; RXDATA = 8'h64;
    WR = 1'b1; BE = 4'b0001; DATAI = 32'd1;
    @(posedge CLK); #1;
    RXSTB = 1'b0; WR = 1'b0; BE = 4'b0000; DATAI = 32'd0;
    checkOutput("t6_discard_len", 32'(len), 0);
    checkOutput("t6_discard_status", 32'(status), 0);
    checkOutput("t6_discard_echoreq", 32'(ECHOREQ), 0);

    @(posedge CLK); #1;
    checkOutput("echo_queue_empty", 32'(echo_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
